mi_loader: RTL and testbench
============================

Name: mi_loader

Overview:
Writer side of the instruction-memory interface that the datapath reads from.
- Receives a length-prefixed byte stream (valid/ready), packs bytes into 32-bit instructions and writes them into MI through we_mi/mi_addr/mi_data.
- Holds the core (uc + datapath) in reset until the program image is fully written, then releases it.
- Sits between the off-chip/bench byte source and the MI write port.

Parameters:
- MI_DEPTH, 1024, MI capacity in 32-bit words; length headers above this are rejected.
- ADDR_W, 64, MI address width; matches the PC width.
- BASE_ADDR, 0, byte address of the first instruction written.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- start  in  1  single-cycle re-arm request; honoured only in DONE or ERRO.
- we_mi  out  1  MI write enable, one-cycle pulse per word.
- mi_addr  out  ADDR_W  MI byte address of the current write.
- mi_data  out  32  instruction word written to MI.
- core_hold  out  1  1 = keep uc/datapath in reset.
- done  out  1  image fully loaded.
- erro  out  1  header length exceeded MI_DEPTH; sticky.

Behaviour:
- Reset values (asynchronous, while rst_n=0): state=LEN0, we_mi=0, mi_addr=BASE_ADDR, mi_data=0, core_hold=1, done=0, erro=0, byte_ready=0. byte_ready rises on the first clock edge after rst_n deasserts.
- Handshake: a byte is accepted on a rising edge when byte_valid && byte_ready. byte_ready does not depend combinationally on byte_valid. Gaps in byte_valid are allowed, with no timeout.
- States:
  - LEN0: byte_ready=1. Accept the low byte of the 16-bit word count N. Go to LEN1.
  - LEN1: byte_ready=1. Accept the high byte of N.
    - N==0 → DONE.
    - N>MI_DEPTH → ERRO.
    - Otherwise → ASM with words_left=N and byte index k=0.
  - ASM: byte_ready=1. Accepted byte goes into word bits [8k+7:8k] (little-endian) and k increments. The 4th accepted byte (k=3) → WRITE.
  - WRITE: byte_ready=0, we_mi=1 for exactly this cycle, mi_data=assembled word, mi_addr=current address. On exit: mi_addr+=4, words_left-=1, k=0. If words_left becomes 0 → DONE, else → ASM.
  - DONE: core_hold=0, done=1, byte_ready=0.
  - ERRO: erro=1, core_hold=1, byte_ready=1. Input bytes are drained and discarded.
- Latency: we_mi is asserted the cycle after the 4th byte handshake. Per-word throughput is 5 cycles minimum.
- Address arithmetic: mi_addr is modulo 2^ADDR_W. The MI_DEPTH check guarantees the last write address is BASE_ADDR+4*(N-1).
- Re-arm: start=1 in DONE or ERRO → LEN0 on the next edge. In the same edge: mi_addr=BASE_ADDR, core_hold=1, done=0, erro=0, k=0. start in any other state is ignored.
- Bytes arriving while ready=0 (WRITE, DONE) are not consumed; the source holds them.
- rst_n asserted mid-load: the partial word is discarded, no we_mi pulse is produced, and the state returns to LEN0. MI contents are not cleared.
- mi_data holds its last written value outside WRITE.

Decomposition:
- Shared package riscv_pkg holds:
  - loader state encoding (LEN0, LEN1, ASM, WRITE, DONE, ERRO);
  - WORD_BYTES=4;
  - INSTR_W=32;
  - default BASE_ADDR.
- One natural sub-module: byte_assembler. It takes the byte, accept strobe and clear, and outputs the 32-bit word plus a word_full flag (k counter + shift/insert logic).
- FSM, address counter and words_left counter stay in mi_loader.

Test Plan:
1. Reset and release: release rst_n → all outputs at reset values; byte_ready=1 one edge later; we_mi=0 throughout.
2. Two-word load: stream 02 00, 33 03 41 00, 13 01 10 00 →
   - we_mi pulses: mi_addr=0/mi_data=0x00410333, then mi_addr=4/mi_data=0x00100113;
   - done=1 and core_hold=0 one edge after the second WRITE.
3. Empty image: header 00 00 → DONE after LEN1 with no we_mi pulse; core_hold=0.
4. Oversize header: MI_DEPTH=1024, header 01 04 (N=1025) → erro=1, core_hold=1, no we_mi; the next 8 bytes are accepted and dropped.
5. Backpressure and gaps: load 1 word with byte_valid low for 3 cycles between bytes, and byte_valid held high during WRITE → exactly one we_mi pulse, correct word, no byte lost or duplicated.
6. Reset mid-load and re-arm:
   - Assert rst_n=0 after 2 of 4 bytes → no write; reload 1 word succeeds at mi_addr=0.
   - Then pulse start in DONE → core_hold=1, second image is written starting again at BASE_ADDR.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// word geometry and the default load address.
package riscv_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned INSTR_W    = 32;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0;

  typedef enum logic [2:0] {
    StLen0,
    StLen1,
    StAsm,
    StWrite,
    StDone,
    StErro
  } ld_state_e;

endpackage

// File: rtl/byte_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; o_word already
// contains the byte being accepted this cycle.
module byte_assembler
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         i_byte,
  input  logic               i_accept,
  input  logic               i_clear,
  output logic [INSTR_W-1:0] o_word,
  output logic               o_word_full
);

  logic [1:0]         r_k;
  logic [INSTR_W-1:0] r_word;

  always_comb begin
    o_word = r_word;
    if (i_accept) begin
      o_word[{r_k, 3'b000} +: 8] = i_byte;
    end
    o_word_full = i_accept && (r_k == 2'(WORD_BYTES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_k <= '0;
    end else if (i_accept) begin
      r_k    <= r_k + 2'd1;
      r_word <= o_word;
    end
  end

endmodule

// File: rtl/mi_loader.sv
// Loads a length-prefixed byte stream into instruction memory one 32-bit
// word at a time and holds the core in reset until the image is complete.
module mi_loader
  import riscv_pkg::*;
#(
  parameter int unsigned        MI_DEPTH  = 1024,
  parameter int unsigned        ADDR_W    = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  input  logic               start,
  output logic               we_mi,
  output logic [ADDR_W-1:0]  mi_addr,
  output logic [INSTR_W-1:0] mi_data,
  output logic               core_hold,
  output logic               done,
  output logic               erro
);

  ld_state_e          r_state, w_state_d;
  logic [ADDR_W-1:0]  r_addr, w_addr_d;
  logic [15:0]        r_words_left, w_words_left_d;
  logic [7:0]         r_len_lo, w_len_lo_d;
  logic [INSTR_W-1:0] r_mi_data, w_mi_data_d;
  // Keeps byte_ready low until the first edge after reset release.
  logic               r_armed;

  logic               w_hs;
  logic [15:0]        w_len;
  logic               w_asm_accept;
  logic               w_asm_clear;
  logic [INSTR_W-1:0] w_word;
  logic               w_word_full;

  assign w_hs    = byte_valid && r_armed;
  assign w_len   = {byte_in, r_len_lo};
  assign mi_addr = r_addr;
  assign mi_data = r_mi_data;

  byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_byte     (byte_in),
    .i_accept   (w_asm_accept),
    .i_clear    (w_asm_clear),
    .o_word     (w_word),
    .o_word_full(w_word_full)
  );

  always_comb begin
    w_state_d       = r_state;
    w_addr_d        = r_addr;
    w_words_left_d  = r_words_left;
    w_len_lo_d      = r_len_lo;
    w_mi_data_d     = r_mi_data;
    w_asm_accept    = 1'b0;
    w_asm_clear     = 1'b0;
    byte_ready      = 1'b0;
    we_mi           = 1'b0;
    core_hold       = 1'b1;
    done            = 1'b0;
    erro            = 1'b0;
    unique case (r_state)
      StLen0: begin
        byte_ready = r_armed;
        if (w_hs) begin
          w_len_lo_d = byte_in;
          w_state_d  = StLen1;
        end
      end
      StLen1: begin
        byte_ready = r_armed;
        if (w_hs) begin
          if (w_len == 16'd0) begin
            w_state_d = StDone;
          end else if (32'(w_len) > MI_DEPTH) begin
            w_state_d = StErro;
          end else begin
            w_words_left_d = w_len;
            w_asm_clear    = 1'b1;
            w_state_d      = StAsm;
          end
        end
      end
      StAsm: begin
        byte_ready   = r_armed;
        w_asm_accept = w_hs;
        if (w_word_full) begin
          w_mi_data_d = w_word;
          w_state_d   = StWrite;
        end
      end
      StWrite: begin
        we_mi          = 1'b1;
        w_addr_d       = r_addr + ADDR_W'(WORD_BYTES);
        w_words_left_d = r_words_left - 16'd1;
        w_asm_clear    = 1'b1;
        w_state_d      = (r_words_left == 16'd1) ? StDone : StAsm;
      end
      StDone: begin
        core_hold = 1'b0;
        done      = 1'b1;
      end
      StErro: begin
        // Drain: bytes are accepted and discarded until re-armed.
        byte_ready = r_armed;
        erro       = 1'b1;
      end
      default: w_state_d = StLen0;
    endcase
    if (start && (r_state == StDone || r_state == StErro)) begin
      w_state_d   = StLen0;
      w_addr_d    = BASE_ADDR;
      w_asm_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StLen0;
      r_addr       <= BASE_ADDR;
      r_words_left <= '0;
      r_len_lo     <= '0;
      r_mi_data    <= '0;
      r_armed      <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_addr       <= w_addr_d;
      r_words_left <= w_words_left_d;
      r_len_lo     <= w_len_lo_d;
      r_mi_data    <= w_mi_data_d;
      r_armed      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mi_loader.sv
// Directed bench for mi_loader: header handling, word packing, handshake
// gaps, oversize rejection, mid-load reset and re-arm.
module tb_mi_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        start = 1'b0;
  logic        we_mi;
  logic [63:0] mi_addr;
  logic [31:0] mi_data;
  logic        core_hold;
  logic        done;
  logic        erro;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];

  mi_loader #(
    .MI_DEPTH (1024),
    .ADDR_W   (64),
    .BASE_ADDR(64'h0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .start     (start),
    .we_mi     (we_mi),
    .mi_addr   (mi_addr),
    .mi_data   (mi_data),
    .core_hold (core_hold),
    .done      (done),
    .erro      (erro)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we_mi) begin
      wr_addr.push_back(mi_addr);
      wr_data.push_back(mi_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      if (byte_ready) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 byte_valid = 1'b0;
    if (!got) check("send_timeout", 64'(got), 64'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset and release
    #12;
    check("rst_we_mi", 64'(we_mi), 64'd0);
    check("rst_mi_addr", mi_addr, 64'h0);
    check("rst_mi_data", 64'(mi_data), 64'h0);
    check("rst_core_hold", 64'(core_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_erro", 64'(erro), 64'd0);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ready_before_edge", 64'(byte_ready), 64'd0);
    @(negedge clk);
    check("rel_ready_after_edge", 64'(byte_ready), 64'd1);
    check("rel_core_hold", 64'(core_hold), 64'd1);

    // 2. Two-word load
    clear_log();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'h03); send_byte(8'h41); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    @(negedge clk);
    check("two_w2_we", 64'(we_mi), 64'd1);
    check("two_w2_ready", 64'(byte_ready), 64'd0);
    check("two_w2_hold", 64'(core_hold), 64'd1);
    @(negedge clk);
    check("two_done", 64'(done), 64'd1);
    check("two_core_hold", 64'(core_hold), 64'd0);
    check("two_done_ready", 64'(byte_ready), 64'd0);
    check("two_nwr", 64'(wr_addr.size()), 64'd2);
    check("two_a0", wr_addr[0], 64'h0);
    check("two_d0", 64'(wr_data[0]), 64'h00410333);
    check("two_a1", wr_addr[1], 64'h4);
    check("two_d1", 64'(wr_data[1]), 64'h00100113);
    check("two_hold_data", 64'(mi_data), 64'h00100113);
    pulse_start();
    check("rearm_hold", 64'(core_hold), 64'd1);
    check("rearm_done", 64'(done), 64'd0);
    check("rearm_addr", mi_addr, 64'h0);
    check("rearm_ready", 64'(byte_ready), 64'd1);

    // 3. Empty image
    clear_log();
    send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    check("empty_done", 64'(done), 64'd1);
    check("empty_hold", 64'(core_hold), 64'd0);
    repeat (3) @(negedge clk);
    check("empty_nwr", 64'(wr_addr.size()), 64'd0);
    pulse_start();

    // 4. Oversize header N=1025
    clear_log();
    send_byte(8'h01); send_byte(8'h04);
    @(negedge clk);
    check("over_erro", 64'(erro), 64'd1);
    check("over_hold", 64'(core_hold), 64'd1);
    check("over_ready", 64'(byte_ready), 64'd1);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
    @(negedge clk);
    check("over_erro_sticky", 64'(erro), 64'd1);
    check("over_done", 64'(done), 64'd0);
    check("over_nwr", 64'(wr_addr.size()), 64'd0);
    pulse_start();
    check("over_rearm_erro", 64'(erro), 64'd0);

    // 5. Gaps and backpressure during WRITE
    clear_log();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF);
    repeat (3) @(negedge clk);
    send_byte(8'hBE);
    repeat (3) @(negedge clk);
    send_byte(8'hAD);
    repeat (3) @(negedge clk);
    send_byte(8'hDE);
    byte_valid = 1'b1;
    byte_in    = 8'hAA;
    @(negedge clk);
    check("gap_we", 64'(we_mi), 64'd1);
    check("gap_write_ready", 64'(byte_ready), 64'd0);
    @(negedge clk);
    check("gap_done", 64'(done), 64'd1);
    check("gap_done_ready", 64'(byte_ready), 64'd0);
    repeat (2) @(negedge clk);
    byte_valid = 1'b0;
    check("gap_nwr", 64'(wr_addr.size()), 64'd1);
    check("gap_a0", wr_addr[0], 64'h0);
    check("gap_d0", 64'(wr_data[0]), 64'hDEADBEEF);
    pulse_start();

    // 6. Reset mid-load, reload, re-arm
    clear_log();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 64'(we_mi), 64'd0);
    check("mid_rst_ready", 64'(byte_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    repeat (2) @(negedge clk);
    check("mid_done", 64'(done), 64'd1);
    check("mid_nwr", 64'(wr_addr.size()), 64'd1);
    check("mid_a0", wr_addr[0], 64'h0);
    check("mid_d0", 64'(wr_data[0]), 64'h11223344);
    pulse_start();
    check("mid_rearm_hold", 64'(core_hold), 64'd1);
    clear_log();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    repeat (2) @(negedge clk);
    check("img2_done", 64'(done), 64'd1);
    check("img2_nwr", 64'(wr_addr.size()), 64'd2);
    check("img2_a0", wr_addr[0], 64'h0);
    check("img2_d0", 64'(wr_data[0]), 64'h04030201);
    check("img2_a1", wr_addr[1], 64'h4);
    check("img2_d1", 64'(wr_data[1]), 64'h08070605);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
